plic: RTL

PLIC -- requirements
Module: plic

---
 rtl/plic.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/plic.sv
// Platform interrupt controller: gateways, priority arbitration, and a claim/complete register window.
// Latency: bus ack one cycle after acceptance; irq_src to irq_ext is three edges after first sampling.
// Backpressure: one transaction per two cycles; requests seen while bus_ack is high are ignored.
module plic #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   irq_src,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [11:0]       bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  output logic              irq_ext
);

  // Word indices of the fixed registers (byte offset / 4).
  localparam logic [9:0] W_PEND  = 10'd32;   // 0x080
  localparam logic [9:0] W_EN    = 10'd64;   // 0x100
  localparam logic [9:0] W_THR   = 10'd128;  // 0x200
  localparam logic [9:0] W_CLAIM = 10'd129;  // 0x204

  logic [NSRC-1:0]   sync1, sync2;
  logic [NSRC:0]     pending, in_service, enable;
  logic [NSRC:0]     pending_nxt, in_service_nxt;
  logic [NSRC:0]     claim_mask, complete_mask;
  logic [PRIO_W-1:0] prio [1:NSRC];
  logic [PRIO_W-1:0] threshold;
  logic [PRIO_W-1:0] best;
  logic [31:0]       winner;
  logic [31:0]       rd_val;
  logic [9:0]        word;
  logic              accept, wr, rd, claim, complete;
  logic              unused_addr;

  assign word        = bus_addr[11:2];
  assign unused_addr = ^bus_addr[1:0];
  assign accept      = bus_req & ~bus_ack;
  assign wr          = accept & bus_we;
  assign rd          = accept & ~bus_we;
  assign claim       = rd && (word == W_CLAIM);
  assign complete    = wr && (word == W_CLAIM);

  // Two-flop synchronizer for the asynchronous source levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  // Arbitration: highest priority among eligible sources; strict compare keeps the lowest ID on ties.
  always_comb begin
    winner = '0;
    best   = '0;
    for (int id = 1; id <= NSRC; id++) begin
      if (pending[id] && enable[id] && (prio[id] > threshold) && (prio[id] > best)) begin
        best   = prio[id];
        winner = 32'(id);
      end
    end
  end

  // Claim/complete one-hot masks and next gateway state; a claim beats a same-edge gateway set.
  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int id = 1; id <= NSRC; id++) begin
      if (claim && (winner == 32'(id)))
        claim_mask[id] = 1'b1;
      if (complete && (bus_wdata == 32'(id)) && in_service[id])
        complete_mask[id] = 1'b1;
    end
    pending_nxt    = (pending | ({sync2, 1'b0} & ~in_service)) & ~claim_mask;
    in_service_nxt = (in_service | claim_mask) & ~complete_mask;
  end

  // Gateway state: pending and in-service bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      in_service <= '0;
    end else begin
      pending    <= pending_nxt;
      in_service <= in_service_nxt;
    end
  end

  // Software-visible configuration: priorities, enables, threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int id = 1; id <= NSRC; id++)
        prio[id] <= '0;
      enable    <= '0;
      threshold <= '0;
    end else if (wr) begin
      for (int id = 1; id <= NSRC; id++)
        if (word == 10'(id))
          prio[id] <= bus_wdata[PRIO_W-1:0];
      if (word == W_EN)
        enable <= {bus_wdata[NSRC:1], 1'b0};
      if (word == W_THR)
        threshold <= bus_wdata[PRIO_W-1:0];
    end
  end

  // Read data mux; the claim word returns the winner as seen before the acceptance edge.
  always_comb begin
    rd_val = '0;
    for (int id = 1; id <= NSRC; id++)
      if (word == 10'(id))
        rd_val[PRIO_W-1:0] = prio[id];
    if (word == W_PEND)
      rd_val[NSRC:0] = pending;
    if (word == W_EN)
      rd_val[NSRC:0] = enable;
    if (word == W_THR)
      rd_val[PRIO_W-1:0] = threshold;
    if (word == W_CLAIM)
      rd_val = winner;
  end

  // Bus response: single-cycle ack with registered data, zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= accept;
      bus_rdata <= rd ? rd_val : 32'd0;
    end
  end

  // Registered interrupt request to the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irq_ext <= 1'b0;
    else
      irq_ext <= (winner != 32'd0);
  end

endmodule
